uart_tx_code: RTL

- UART transmitter; counterpart to the color-mixer UART receive path.
- Serialises one 8-bit byte per request as a frame: start bit (0), 8 data bits LSB first, then STOP_BITS stop bits (1).
- Bit timing comes from an internal clock-enable counter on the single system clock. No divided clocks, no tri-state controls.
- Used to echo or acknowledge colour bytes back to the host.

---
 rtl/uart_tx_code.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/uart_tx_code.sv
// rtl/uart_tx_code.sv - UART transmitter, 8N1/8N2 framing on a single clock
//
// Ports:
//   clk       system clock, all logic on the rising edge
//   reset     synchronous active-low reset
//   tx_start  frame request, only looked at while idle
//   tx_data   byte to send, captured on the accepted tx_start edge
//   tx        serial line, idles high
//   tx_busy   high while a frame is in progress
//   tx_done   one-cycle pulse after the last stop bit
module uart_tx_code #(
  parameter int CLKS_PER_BIT = 8000,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       tx,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    DATA_LAST  = 3'd7;
  localparam logic [2:0]    STOP_LAST  = 3'(STOP_BITS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [TW-1:0] r_timer, w_timer_nxt;
  logic [2:0]    r_index, w_index_nxt;
  logic [7:0]    r_shift, w_shift_nxt;
  logic          r_tx,    w_tx_nxt;
  logic          r_busy,  w_busy_nxt;
  logic          r_done,  w_done_nxt;
  logic          w_bit_end;

  assign w_bit_end = (r_timer == TIMER_LAST);

  // Next-state logic. Output registers are loaded with the value that the
  // *next* state drives, so tx/busy/done change on the same edge as the state.
  always_comb begin
    w_state_nxt = r_state;
    w_timer_nxt = r_timer;
    w_index_nxt = r_index;
    w_shift_nxt = r_shift;
    w_tx_nxt    = r_tx;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_tx_nxt    = 1'b1;
        w_busy_nxt  = 1'b0;
        w_timer_nxt = '0;
        w_index_nxt = '0;
        if (tx_start) begin
          w_shift_nxt = tx_data;
          w_state_nxt = S_START;
          w_tx_nxt    = 1'b0;
          w_busy_nxt  = 1'b1;
        end
      end

      S_START: begin
        if (w_bit_end) begin
          w_timer_nxt = '0;
          w_index_nxt = '0;
          w_state_nxt = S_DATA;
          w_tx_nxt    = r_shift[0];
        end else begin
          w_timer_nxt = r_timer + TW'(1);
        end
      end

      S_DATA: begin
        if (w_bit_end) begin
          w_timer_nxt = '0;
          w_shift_nxt = {1'b0, r_shift[7:1]};
          if (r_index == DATA_LAST) begin
            w_index_nxt = '0;
            w_state_nxt = S_STOP;
            w_tx_nxt    = 1'b1;
          end else begin
            w_index_nxt = r_index + 3'd1;
            // r_shift[1] becomes shift[0] after this edge's shift
            w_tx_nxt    = r_shift[1];
          end
        end else begin
          w_timer_nxt = r_timer + TW'(1);
        end
      end

      S_STOP: begin
        w_tx_nxt = 1'b1;
        if (w_bit_end) begin
          w_timer_nxt = '0;
          if (r_index == STOP_LAST) begin
            w_index_nxt = '0;
            w_state_nxt = S_IDLE;
            w_busy_nxt  = 1'b0;
            w_done_nxt  = 1'b1;
          end else begin
            w_index_nxt = r_index + 3'd1;
          end
        end else begin
          w_timer_nxt = r_timer + TW'(1);
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
        w_tx_nxt    = 1'b1;
        w_busy_nxt  = 1'b0;
        w_timer_nxt = '0;
        w_index_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_timer <= '0;
      r_index <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_timer <= w_timer_nxt;
      r_index <= w_index_nxt;
      r_shift <= w_shift_nxt;
      r_tx    <= w_tx_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
    end
  end

  assign tx      = r_tx;
  assign tx_busy = r_busy;
  assign tx_done = r_done;

endmodule
